// File: rtl/uart_tx_engine.sv
// UART transmit framing engine: start, 8 data bits LSB first, optional even parity, stop.
// Defining UART_TX_PARITY_EN inserts an even parity bit between d[7] and stop.
module uart_tx_engine #(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx,
   output logic       doit,
   output logic       btu
);

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [TW-1:0] T_LAST   = TW'(BAUD_DIV - 1);
   localparam logic [3:0]    IDX_LAST = 4'(FRAME_BITS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state, state_nxt;
   logic [FRAME_BITS-1:0] shreg;
   logic [FRAME_BITS-1:0] frame;
   logic [TW-1:0]         timer;
   logic [3:0]            bit_idx;
   logic                  accept;
   logic                  last_bit;

`ifdef UART_TX_PARITY_EN
   assign frame = {1'b1, ^data, data, 1'b0};
`else
   assign frame = {1'b1, data, 1'b0};
`endif

   assign accept   = load && ready;
   assign last_bit = btu && (bit_idx == IDX_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept)   state_nxt = SEND;
         SEND: if (last_bit) state_nxt = IDLE;
         default:            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE);
      doit  = (state == SEND);
      btu   = (state == SEND) && (timer == T_LAST);
   end

   // tx is registered from the value shreg[0] takes after this edge, so it equals shreg[0] during SEND
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         timer   <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
      end else if (state == IDLE) begin
         timer   <= '0;
         bit_idx <= '0;
         if (accept) begin
            shreg <= frame;
            tx    <= 1'b0;
         end else begin
            tx    <= 1'b1;
         end
      end else if (btu) begin
         timer   <= '0;
         shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
         bit_idx <= bit_idx + 4'd1;
         tx      <= last_bit ? 1'b1 : shreg[1];
      end else begin
         timer   <= timer + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: BAUD_DIV=4 main instance, BAUD_DIV=2 divider-corner instance.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int BD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       load, load2;
   logic [7:0] data, data2;
   logic       ready, tx, doit, btu;
   logic       ready2, tx2, doit2, btu2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_engine #(.BAUD_DIV(BD)) dut (
      .clk(clk), .rst(rst), .load(load), .data(data),
      .ready(ready), .tx(tx), .doit(doit), .btu(btu)
   );

   uart_tx_engine #(.BAUD_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .load(load2), .data(data2),
      .ready(ready2), .tx(tx2), .doit(doit2), .btu(btu2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
      frame_of = {1'b1, ^d, d, 1'b0};
`else
      frame_of = {1'b1, d, 1'b0};
`endif
   endfunction

   // Entered #1 after the accepting edge; leaves at the negedge of the first idle cycle.
   task automatic frame_check(input string tag, input logic [7:0] d, input int pulse_at);
      logic [FB-1:0] f;
      int            nbtu;
      int            b;
      int            ph;
      f    = frame_of(d);
      nbtu = 0;
      for (int i = 1; i <= FB*BD; i++) begin
         if (pulse_at != 0) begin
            load = (i == pulse_at);
            if (i == pulse_at) data = 8'hFF;
         end
         @(negedge clk);
         b  = (i - 1) / BD;
         ph = (i - 1) % BD;
         chk({tag, "_tx"},    {31'd0, tx},    {31'd0, f[b]});
         chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
         chk({tag, "_doit"},  {31'd0, doit},  32'd1);
         chk({tag, "_btu"},   {31'd0, btu},   (ph == BD-1) ? 32'd1 : 32'd0);
         if (btu) nbtu++;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk({tag, "_nbtu"},       nbtu,           FB);
      chk({tag, "_end_ready"},  {31'd0, ready}, 32'd1);
      chk({tag, "_end_doit"},   {31'd0, doit},  32'd0);
      chk({tag, "_end_tx"},     {31'd0, tx},    32'd1);
      chk({tag, "_end_btu"},    {31'd0, btu},   32'd0);
   endtask

   task automatic start_frame(input logic [7:0] d);
      load = 1'b1;
      data = d;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   initial begin
      int nbtu2;
      rst = 1'b1; load = 1'b0; data = 8'h00; load2 = 1'b0; data2 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx",    {31'd0, tx},     32'd1);
      chk("rst_ready", {31'd0, ready},  32'd1);
      chk("rst_doit",  {31'd0, doit},   32'd0);
      chk("rst_btu",   {31'd0, btu},    32'd0);
      chk("rst_tx2",   {31'd0, tx2},    32'd1);
      chk("rst_rdy2",  {31'd0, ready2}, 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      start_frame(8'hA5);
      frame_check("a5", 8'hA5, 0);
      @(posedge clk); #1;

`ifdef UART_TX_PARITY_EN
      start_frame(8'h03);
      frame_check("p03", 8'h03, 0);
      @(posedge clk); #1;
      start_frame(8'h07);
      frame_check("p07", 8'h07, 0);
      @(posedge clk); #1;
`endif

      start_frame(8'h55);
      frame_check("busy", 8'h55, 10);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("busy_idle_ready", {31'd0, ready}, 32'd1);
         chk("busy_idle_tx",    {31'd0, tx},    32'd1);
         chk("busy_idle_doit",  {31'd0, doit},  32'd0);
      end
      @(posedge clk); #1;

      load = 1'b1;
      data = 8'h0F;
      @(posedge clk); #1;
      data = 8'hF0;
      frame_check("b2b_0f", 8'h0F, 0);
      @(posedge clk); #1;
      load = 1'b0;
      frame_check("b2b_f0", 8'hF0, 0);
      @(posedge clk); #1;

      start_frame(8'hC3);
      repeat (16) @(posedge clk);
      #1;
      chk("mid_doit", {31'd0, doit}, 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_tx",    {31'd0, tx},    32'd1);
      chk("arst_ready", {31'd0, ready}, 32'd1);
      chk("arst_doit",  {31'd0, doit},  32'd0);
      chk("arst_btu",   {31'd0, btu},   32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      start_frame(8'h3C);
      frame_check("post_rst", 8'h3C, 0);
      @(posedge clk); #1;

      load2 = 1'b1;
      data2 = 8'h00;
      @(posedge clk); #1;
      load2 = 1'b0;
      nbtu2 = 0;
      for (int i = 1; i <= FB*2; i++) begin
         @(negedge clk);
         chk("div2_tx",   {31'd0, tx2},   (((i - 1) / 2) == FB-1) ? 32'd1 : 32'd0);
         chk("div2_btu",  {31'd0, btu2},  ((i % 2) == 0) ? 32'd1 : 32'd0);
         chk("div2_doit", {31'd0, doit2}, 32'd1);
         if (btu2) nbtu2++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("div2_nbtu",  nbtu2,            FB);
      chk("div2_ready", {31'd0, ready2},  32'd1);
      chk("div2_btu_idle", {31'd0, btu2}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
